// File: rtl/iter_divider_rnd.sv
// iter_divider_rnd: restoring radix-2 unsigned divider, one quotient bit per clock, tag sideband.
// Latency: WIDTH+1 edges from accept to out_valid with DIV_ROUND_EN, WIDTH edges without.
// Backpressure: one operation in flight; in_ready low until the result handshake completes.
//
// Optional feature macro: DIV_ROUND_EN (adds a ROUND state; quotient rounded to nearest, half up).
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, dividend, divisor, in_tag         operand handshake
//   out_valid/out_ready, quotient, remainder,
//   div_by_zero, out_tag                                 result handshake
//   busy                                                 FSM not in IDLE
module iter_divider_rnd #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_sh;    // dividend, shifted left one bit per CALC cycle
  logic [WIDTH-1:0] dvd_org;   // original dividend, returned as remainder on divide-by-zero
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;      // partial remainder; always < divisor between steps
  logic [WIDTH-1:0] q;
  logic [TAG_W-1:0] tag_r;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;   // WIDTH+1-bit working remainder for this step
  logic             q_bit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             dz;
  logic             load_out;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  // One restoring step.
  always_comb begin
    shifted  = {prem, dvd_sh[WIDTH-1]};
    q_bit    = (shifted >= {1'b0, dvs});
    prem_nxt = q_bit ? WIDTH'(shifted - {1'b0, dvs}) : WIDTH'(shifted);
    q_nxt    = {q[WIDTH-2:0], q_bit};
  end

  assign dz = (dvs == '0);

`ifdef DIV_ROUND_EN
  logic round_up;
  // 2*rem compared at WIDTH+1 bits; divisor >= 2 keeps q+1 in range, divisor 1 never rounds.
  assign round_up = ({prem, 1'b0} >= {1'b0, dvs});
  assign load_out = (state == S_ROUND);
  assign fin_q    = dz ? '1 : q + WIDTH'(round_up);
  assign fin_r    = dz ? dvd_org : prem;
`else
  assign load_out = (state == S_CALC) && (count == '0);
  assign fin_q    = dz ? '1 : q_nxt;
  assign fin_r    = dz ? dvd_org : prem_nxt;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (count == '0) begin
`ifdef DIV_ROUND_EN
          state_nxt = S_ROUND;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef DIV_ROUND_EN
      S_ROUND: state_nxt = S_DONE;
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_sh      <= '0;
      dvd_org     <= '0;
      dvs         <= '0;
      prem        <= '0;
      q           <= '0;
      tag_r       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_tag     <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        dvd_sh  <= dividend;
        dvd_org <= dividend;
        dvs     <= divisor;
        tag_r   <= in_tag;
        prem    <= '0;
        q       <= '0;
        count   <= CW'(WIDTH - 1);
      end else if (state == S_CALC) begin
        dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
        prem   <= prem_nxt;
        q      <= q_nxt;
        count  <= count - 1'b1;
      end
      // Result registers change only on the edge entering DONE.
      if (load_out) begin
        quotient    <= fin_q;
        remainder   <= fin_r;
        div_by_zero <= dz;
        out_tag     <= tag_r;
      end
    end
  end

endmodule
